// File: rtl/color_fsm_driver_if.sv
// Request/completion bus and colour-FSM command/status link for color_fsm_driver.
// master = host/sequencer side (also sources FSM status), slave = the driver.
interface color_fsm_driver_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_color;
  logic [1:0] status;
  logic [1:0] cmd;
  logic       done_valid;
  logic [1:0] done_code;
  logic [3:0] attempts;

  modport master (
    output req_valid, req_color, status,
    input  req_ready, cmd, done_valid, done_code, attempts
  );

  modport slave (
    input  req_valid, req_color, status,
    output req_ready, cmd, done_valid, done_code, attempts
  );
endinterface

// File: rtl/color_fsm_driver.sv
// Drives a two-colour FSM to a requested colour with bounded toggle retries,
// reporting a one-cycle done pulse, result code and attempt count.
module color_fsm_driver #(
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  color_fsm_driver_if.slave  bus
);

  localparam int unsigned CNT_W = 4;

  localparam logic [1:0]       ST_BLUE    = 2'h1;
  localparam logic [1:0]       ST_RED     = 2'h2;
  localparam logic [1:0]       CMD_HOLD   = 2'h0;
  localparam logic [1:0]       CMD_TOGGLE = 2'h1;
  localparam logic [1:0]       CODE_OK    = 2'd0;
  localparam logic [1:0]       CODE_RETRY = 2'd1;
  localparam logic [1:0]       CODE_BAD   = 2'd2;
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ATT_MAX    = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_TOGGLE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_target;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_attempts;
  logic [1:0]       r_done_code;
  logic             r_req_ready;
  logic [1:0]       r_cmd;
  logic             r_done_valid;

  state_t           w_state_nxt;
  logic             w_target_nxt;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] w_attempts_nxt;
  logic [1:0]       w_code_nxt;
  logic             w_status_legal;
  logic             w_at_target;

  assign w_status_legal = (bus.status == ST_BLUE) || (bus.status == ST_RED);
  assign w_at_target    = r_target ? (bus.status == ST_RED) : (bus.status == ST_BLUE);

  // Next-state and datapath update
  always_comb begin
    w_state_nxt    = r_state;
    w_target_nxt   = r_target;
    w_timer_nxt    = r_timer;
    w_attempts_nxt = r_attempts;
    w_code_nxt     = r_done_code;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid && r_req_ready) begin
          w_state_nxt    = S_CHECK;
          w_target_nxt   = bus.req_color;
          w_timer_nxt    = '0;
          w_attempts_nxt = '0;
          w_code_nxt     = CODE_OK;
        end
      end
      S_CHECK: begin
        if (!w_status_legal) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = CODE_BAD;
        end else if (w_at_target) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = CODE_OK;
        end else begin
          w_state_nxt = S_TOGGLE;
        end
      end
      S_TOGGLE: begin
        w_attempts_nxt = r_attempts + CNT_W'(1);
        w_timer_nxt    = '0;
        w_state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        // Match wins over illegal status, which wins over timeout
        if (w_at_target) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = CODE_OK;
        end else if (!w_status_legal) begin
          w_state_nxt = S_DONE;
          w_code_nxt  = CODE_BAD;
        end else if (r_timer == TIMER_LAST) begin
          if (r_attempts >= ATT_MAX) begin
            w_state_nxt = S_DONE;
            w_code_nxt  = CODE_RETRY;
          end else begin
            w_state_nxt = S_TOGGLE;
          end
        end else begin
          w_timer_nxt = r_timer + CNT_W'(1);
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registers; outputs are pre-decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_target     <= 1'b0;
      r_timer      <= '0;
      r_attempts   <= '0;
      r_done_code  <= CODE_OK;
      r_req_ready  <= 1'b1;
      r_cmd        <= CMD_HOLD;
      r_done_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_target     <= w_target_nxt;
      r_timer      <= w_timer_nxt;
      r_attempts   <= w_attempts_nxt;
      r_done_code  <= w_code_nxt;
      r_req_ready  <= (w_state_nxt == S_IDLE);
      r_cmd        <= (w_state_nxt == S_TOGGLE) ? CMD_TOGGLE : CMD_HOLD;
      r_done_valid <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.cmd        = r_cmd;
  assign bus.done_valid = r_done_valid;
  assign bus.done_code  = r_done_code;
  assign bus.attempts   = r_attempts;

endmodule

// File: tb/tb_color_fsm_driver.sv
// Scoreboard bench for color_fsm_driver: expected done/cmd events are queued
// at request time and matched against the DUT on the falling clock edge.
module tb_color_fsm_driver;

  localparam int unsigned MAX_RETRY = 3;
  localparam int unsigned TIMEOUT   = 4;

  typedef struct {
    int         cyc;
    logic [1:0] code;
    logic [3:0] att;
  } exp_done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  color_fsm_driver_if bus_if ();

  color_fsm_driver #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Status source: behavioural colour FSM (mode 0) or a forced value (mode 1)
  logic       st_mode  = 1'b1;
  logic [1:0] st_force = 2'h1;
  logic       model_red = 1'b0;
  always @(posedge clk) if (!st_mode && bus_if.cmd == 2'h1) model_red <= ~model_red;
  assign bus_if.status = st_mode ? st_force : (model_red ? 2'h2 : 2'h1);

  int n_checks = 0;
  int n_pass   = 0;

  exp_done_t exp_done[$];
  int        exp_cmd[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.cmd != 2'h0) begin
        check_eq("cmd_value", 32'(bus_if.cmd), 32'd1);
        check_eq("cmd_expected", 32'(exp_cmd.size() != 0), 32'd1);
        if (exp_cmd.size() != 0) check_eq("cmd_cycle", 32'(cyc), 32'(exp_cmd.pop_front()));
      end
      if (bus_if.done_valid) begin
        check_eq("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) begin
          exp_done_t e;
          e = exp_done.pop_front();
          check_eq("done_cycle", 32'(cyc), 32'(e.cyc));
          check_eq("done_code", 32'(bus_if.done_code), 32'(e.code));
          check_eq("attempts", 32'(bus_if.attempts), 32'(e.att));
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!bus_if.req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("req_ready", 32'(bus_if.req_ready), 32'd1);
  endtask

  task automatic push_done(input int c, input logic [1:0] code, input logic [3:0] att);
    exp_done_t e;
    e.cyc = c; e.code = code; e.att = att;
    exp_done.push_back(e);
  endtask

  // Caller is one step after a rising edge with req_ready high
  task automatic issue(input logic color);
    bus_if.req_valid = 1'b1;
    bus_if.req_color = color;
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_color = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_done.size() != 0 || exp_cmd.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_done_q", 32'(exp_done.size()), 32'd0);
    check_eq("drain_cmd_q", 32'(exp_cmd.size()), 32'd0);
    exp_done.delete();
    exp_cmd.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    int step;
    step = int'(TIMEOUT) + 1;

    // Reset held two cycles with random inputs
    bus_if.req_valid = $urandom_range(0, 1);
    bus_if.req_color = $urandom_range(0, 1);
    st_force         = 2'($urandom_range(0, 3));
    @(negedge clk);
    check_eq("rst_cmd", 32'(bus_if.cmd), 32'd0);
    check_eq("rst_done_valid", 32'(bus_if.done_valid), 32'd0);
    check_eq("rst_attempts", 32'(bus_if.attempts), 32'd0);
    bus_if.req_valid = $urandom_range(0, 1);
    st_force         = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.req_valid = 1'b0;
    st_force = 2'h1;
    @(posedge clk); #1;
    check_eq("rst_req_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("rst_done_code", 32'(bus_if.done_code), 32'd0);

    // Already at target: Red requested, status Red
    st_mode = 1'b1; st_force = 2'h2;
    wait_ready();
    t0 = cyc;
    push_done(t0 + 2, 2'd0, 4'd0);
    issue(1'b1);
    drain();

    // Single toggle against the behavioural FSM, starting Blue
    st_mode = 1'b0;
    wait_ready();
    t0 = cyc;
    exp_cmd.push_back(t0 + 2);
    push_done(t0 + 4, 2'd0, 4'd1);
    issue(1'b1);
    @(posedge clk); #1;
    check_eq("pre_toggle_status", 32'(bus_if.status), 32'h1);
    @(posedge clk); #1;
    check_eq("post_toggle_status", 32'(bus_if.status), 32'h2);
    drain();

    // Unresponsive FSM stuck Blue, Red requested
    st_mode = 1'b1; st_force = 2'h1;
    wait_ready();
    t0 = cyc;
    for (int k = 0; k < int'(MAX_RETRY); k++) exp_cmd.push_back(t0 + 2 + k * step);
    push_done(t0 + 2 + int'(MAX_RETRY) * step, 2'd1, 4'(MAX_RETRY));
    issue(1'b1);
    drain();

    // Illegal status at CHECK
    st_force = 2'h3;
    wait_ready();
    t0 = cyc;
    push_done(t0 + 2, 2'd2, 4'd0);
    issue(1'b0);
    drain();

    // Status goes illegal (2'h0) during the first WAIT cycle
    st_force = 2'h1;
    wait_ready();
    t0 = cyc;
    exp_cmd.push_back(t0 + 2);
    push_done(t0 + 4, 2'd2, 4'd1);
    issue(1'b1);
    repeat (2) begin @(posedge clk); #1; end
    st_force = 2'h0;
    drain();

    // Reset during WAIT after the first toggle
    st_force = 2'h1;
    wait_ready();
    t0 = cyc;
    exp_cmd.push_back(t0 + 2);
    issue(1'b1);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("mid_wait_attempts", 32'(bus_if.attempts), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("mid_rst_cmd", 32'(bus_if.cmd), 32'd0);
    check_eq("mid_rst_attempts", 32'(bus_if.attempts), 32'd0);
    check_eq("mid_rst_ready", 32'(bus_if.req_ready), 32'd1);
    check_eq("mid_rst_done_valid", 32'(bus_if.done_valid), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    check_eq("mid_rst_cmd_q", 32'(exp_cmd.size()), 32'd0);

    // Normal completion afterwards, then a back-to-back request
    st_mode = 1'b0;
    wait_ready();
    t0 = cyc;
    exp_cmd.push_back(t0 + 2);
    push_done(t0 + 4, 2'd0, 4'd1);
    issue(~model_red);
    wait_ready();
    t1 = cyc;
    check_eq("b2b_spacing", 32'(t1 - t0), 32'd5);
    push_done(t1 + 2, 2'd0, 4'd0);
    issue(model_red);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/color_fsm_driver.md
# color_fsm_driver

Initiator-side controller for the two-colour (Blue/Red) state machine block. It accepts a target-colour request over a valid/ready handshake and issues single-cycle toggle commands on the FSM's 2-bit command input. It watches the FSM's 2-bit colour status output until the target colour is reached, retries are exhausted, or an illegal status is seen. It sits between a host/sequencer and one colour FSM instance, and reports completion with a one-cycle done pulse, a result code and an attempt count.

## Interface
- MAX_RETRY, 3: maximum toggle commands per request; legal range 1..15.
- TIMEOUT, 4: WAIT cycles per attempt before the status is judged unresponsive; legal range 1..15.

- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid && req_ready.
- req_color  in  1  target colour: 0 = Blue, 1 = Red; latched on accept.
- status  in  2  FSM colour output: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are illegal.
- cmd  out  2  FSM command input: 2'h1 = toggle, 2'h0 = hold; 2'h2 and 2'h3 are never driven.
- done_valid  out  1  one-cycle completion pulse; no backpressure.
- done_code  out  2  result: 0 = OK, 1 = RETRY_EXHAUSTED, 2 = BAD_STATUS; 3 is never driven.
- attempts  out  4  toggle commands issued for the last request.

## Operation
- States: IDLE, CHECK, TOGGLE, WAIT, DONE. Registered 3-bit state; all outputs are decoded from registered state and registers (Moore).
- IDLE
  - req_ready = 1, cmd = 0.
  - On accept: latch req_color, clear attempts and timer, go to CHECK.
- CHECK: decode status.
  - Illegal status → DONE, code 2.
  - Status equals target → DONE, code 0.
  - Otherwise → TOGGLE.
- TOGGLE
  - cmd = 2'h1 for exactly this one cycle.
  - attempts += 1; timer cleared; → WAIT.
- WAIT: cmd = 0; each cycle, evaluated in this order:
  1. Status equals target → DONE, code 0.
  2. Illegal status → DONE, code 2.
  3. Timer == TIMEOUT-1 and attempts == MAX_RETRY → DONE, code 1.
  4. Timer == TIMEOUT-1 and attempts < MAX_RETRY → TOGGLE.
  5. Otherwise timer += 1.
- DONE
  - done_valid = 1 for one cycle; → IDLE.
  - done_code and attempts are held until the next accept.
- Width rules
  - attempts never exceeds MAX_RETRY, so it cannot wrap.
  - Timer is 4 bits and compares against TIMEOUT-1.
- Target match: status 2'h1 matches req_color 0; status 2'h2 matches req_color 1.
- req_valid outside IDLE is ignored; the requester must hold req_valid until accepted.

## Timing
- Reset values: state = IDLE, req_ready = 1 (after the reset edge), cmd = 2'h0, done_valid = 0, done_code = 0, attempts = 0, timer = 0.
- Reset mid-operation
  - rst sampled high in any state → IDLE at that edge.
  - No done_valid is produced, and no further cmd pulse follows.
- The FSM updates on the edge after it samples cmd, and its status is combinational from its state. The first WAIT cycle therefore already sees the post-toggle colour.
- Latency, with accept at cycle 0:
  - Already at target: CHECK at 1, done_valid at 2.
  - One toggle: cmd pulse at 2, status changes at 3, done_valid at 4.
  - Unresponsive FSM: attempt k's toggle occurs at cycle 2 + (k-1)(TIMEOUT+1); done_valid at 2 + MAX_RETRY·(TIMEOUT+1).
- Back-to-back requests: req_ready rises the cycle after done_valid, so the minimum request-to-request spacing is 3 cycles.
- Status changing during CHECK is sampled only in that cycle; there is no synchroniser, because status is same-clock.

## Test plan
- Reset: hold rst 2 cycles with random inputs → cmd = 0, done_valid = 0, attempts = 0; req_ready = 1 after the release edge.
- Already at target: status = 2'h2, request Red at cycle 0 → no cmd pulse; done_valid at cycle 2 with code 0, attempts 0.
- Single toggle against a behavioural FSM model starting Blue, request Red → cmd = 2'h1 only at cycle 2; status 2'h2 at cycle 3; done at cycle 4, code 0, attempts 1.
- Unresponsive, status stuck at 2'h1, request Red, MAX_RETRY = 3, TIMEOUT = 4 → cmd pulses at cycles 2, 7, 12; done at cycle 17 with code 1, attempts 3.
- Illegal status 2'h3 at CHECK → done at cycle 2 with code 2, attempts 0. A separate case with status going to 2'h0 in WAIT → done on the following cycle with code 2.
- Reset mid-WAIT, after the first toggle → next cycle is IDLE with cmd = 0 and attempts = 0, and no done_valid is seen. A new request then completes normally.
